// File: rtl/output_drain_ctrl.sv
// output_drain_ctrl: captures LANES results per handshake and stores them one word per cycle into a 2^ADDR_W buffer
// Ports: res_valid/res_data/res_ready = result vector handshake; send_active stalls stores;
// ptr_clr clears wr_ptr and count while idle; st_data/st_addr/st_en = buffer store port;
// count/full = occupancy; done = one-cycle pulse after the last lane is stored.
// Optional macro DRAIN_RELU_EN: zero negative (two's-complement) words on the way out.
module output_drain_ctrl #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    res_valid,
  input  logic [LANES*DATA_W-1:0] res_data,
  output logic                    res_ready,
  input  logic                    send_active,
  input  logic                    ptr_clr,
  output logic [DATA_W-1:0]       st_data,
  output logic [ADDR_W-1:0]       st_addr,
  output logic                    st_en,
  output logic [ADDR_W:0]         count,
  output logic                    full,
  output logic                    done
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LIDX_W = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t                  state_q, state_d;
  logic [LIDX_W-1:0]       lane_idx_q, lane_idx_d;
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]         count_q, count_d;
  logic                    done_q, done_d;
  logic [LANES*DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0]       lane;
  logic                    last;
  always_comb begin
    lane      = shadow_q[lane_idx_q*DATA_W +: DATA_W];
    last      = lane_idx_q == LIDX_W'(LANES-1);
    // room for a whole vector is required so count can never pass DEPTH
    res_ready = state_q == IDLE && !ptr_clr && count_q <= (ADDR_W+1)'(DEPTH-LANES);
    st_en     = state_q == DRAIN && !send_active;
    st_addr   = wr_ptr_q;
`ifdef DRAIN_RELU_EN
    st_data   = lane[DATA_W-1] ? '0 : lane;
`else
    st_data   = lane;
`endif
    count     = count_q;
    full      = count_q == (ADDR_W+1)'(DEPTH);
    done      = done_q;
  end
  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    shadow_d   = shadow_q;
    done_d     = 1'b0;
    if (state_q == IDLE) begin
      wr_ptr_d = ptr_clr ? '0 : wr_ptr_q;
      count_d  = ptr_clr ? '0 : count_q;
      if (res_valid && res_ready) begin
        shadow_d   = res_data;
        lane_idx_d = '0;
        state_d    = DRAIN;
      end
    end else if (st_en) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      count_d    = count_q + 1'b1;
      lane_idx_d = last ? '0 : lane_idx_q + 1'b1;
      state_d    = last ? IDLE : DRAIN;
      done_d     = last;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_idx_q <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      shadow_q   <= shadow_d;
    end
  end
endmodule

// File: tb/tb_output_drain_ctrl.sv
// tb_output_drain_ctrl: directed checks of output_drain_ctrl with hand-computed expectations
module tb_output_drain_ctrl;
  logic         clk = 1'b0, rst = 1'b1, res_valid = 1'b0, send_active = 1'b0, ptr_clr = 1'b0;
  logic [127:0] res_data = '0;
  logic         res_ready, st_en, full, done;
  logic [31:0]  st_data;
  logic [3:0]   st_addr;
  logic [4:0]   count;
  int           tests = 0, fails = 0;
  output_drain_ctrl dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .send_active(send_active), .ptr_clr(ptr_clr), .st_data(st_data), .st_addr(st_addr),
    .st_en(st_en), .count(count), .full(full), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_vec(input logic [127:0] v, input logic [127:0] ev, input logic [3:0] base,
                          input int stall, input int clr, input logic [4:0] cnt);
    res_valid = 1'b1;
    res_data  = v;
    #1 chk("accept_ready", res_ready, 1);
    tick;
    res_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == stall) begin
        send_active = 1'b1;
        #1 chk("stall_en", st_en, 0);
        tick;
        send_active = 1'b0;
      end
      ptr_clr = (i == clr);
      #1 chk("st_en", st_en, 1);
      chk("st_addr", st_addr, base + 4'(i));
      chk("st_data", st_data, ev[i*32 +: 32]);
      chk("done_early", done, 0);
      tick;
      ptr_clr = 1'b0;
    end
    #1 chk("done", done, 1);
    chk("count", count, cnt);
    chk("ready_after", res_ready, cnt <= 5'd12);
    tick;
    chk("done_once", done, 0);
  endtask
  initial begin
    tick;
    tick;
    rst = 1'b0;
    #1 chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_done", done, 0);
    chk("rst_st_en", st_en, 0);
    chk("rst_ready", res_ready, 1);
    chk("rst_addr", st_addr, 0);
    chk("rst_data", st_data, 0);
    send_vec({32'd4, 32'd3, 32'd2, 32'd1}, {32'd4, 32'd3, 32'd2, 32'd1}, 4'd0, -1, -1, 5'd4);
    send_vec({32'd4, 32'd3, 32'd2, 32'd1}, {32'd4, 32'd3, 32'd2, 32'd1}, 4'd4, 1, -1, 5'd8);
    send_vec({32'hA3, 32'hA2, 32'hA1, 32'hA0}, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'd8, -1, -1, 5'd12);
    send_vec({32'hB3, 32'hB2, 32'hB1, 32'hB0}, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'd12, -1, -1, 5'd16);
    res_valid = 1'b1;
    res_data  = {4{32'hDEAD}};
    #1 chk("full_flag", full, 1);
    chk("full_count", count, 16);
    chk("full_ready", res_ready, 0);
    tick;
    chk("full_no_store", st_en, 0);
    chk("full_hold", count, 16);
    tick;
    chk("full_no_store2", st_en, 0);
    res_valid = 1'b0;
    ptr_clr = 1'b1;
    #1 chk("clr_blocks_ready", res_ready, 0);
    tick;
    ptr_clr = 1'b0;
    #1 chk("clr_count", count, 0);
    chk("clr_full", full, 0);
    chk("clr_ready", res_ready, 1);
    send_vec({32'd8, 32'd7, 32'd6, 32'd5}, {32'd8, 32'd7, 32'd6, 32'd5}, 4'd0, -1, 1, 5'd4);
    res_valid = 1'b1;
    res_data  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    #1 tick;
    res_valid = 1'b0;
    #1 chk("mid_addr0", st_addr, 4);
    chk("mid_data0", st_data, 32'hC0);
    tick;
    #1 chk("mid_addr1", st_addr, 5);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1 chk("mid_rst_st_en", st_en, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", res_ready, 1);
    chk("mid_rst_done", done, 0);
    send_vec({4{32'd9}}, {4{32'd9}}, 4'd0, -1, -1, 5'd4);
`ifdef DRAIN_RELU_EN
    send_vec({32'd0, 32'h80000000, 32'd7, 32'hFFFFFFFB}, {32'd0, 32'd0, 32'd7, 32'd0}, 4'd4, -1, -1, 5'd8);
`else
    send_vec({32'd0, 32'h80000000, 32'd7, 32'hFFFFFFFB}, {32'd0, 32'h80000000, 32'd7, 32'hFFFFFFFB}, 4'd4, -1, -1, 5'd8);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
